// File: rtl/rf_pkg.sv
// Shared types and constants for the register file write path.
// Contents: address/data widths, the write payload struct, and a one-hot
// decode helper used to build the pending-write mask.
package rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } rf_wr_t;

    // One-hot decode of a destination register number.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] oh;
        oh     = '0;
        oh[rd] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO of register file writes for long-latency results.
// Ports:
//   clk, rst       clock, async active-low reset
//   push_i/data_i  enqueue one write (caller guarantees not full)
//   pop_i/head_o   dequeue the head write (caller guarantees not empty)
//   count_o        registered occupancy; full_o / empty_o derived from it
//   nxt_valid_o    per-entry valid after this edge's push/pop
//   nxt_rd_o       per-entry destination register after this edge's push/pop
module rf_wr_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push_i,
    input  rf_wr_t                               data_i,
    input  logic                                 pop_i,
    output rf_wr_t                               head_o,
    output logic [$clog2(DEPTH+1)-1:0]           count_o,
    output logic                                 full_o,
    output logic                                 empty_o,
    output logic [DEPTH-1:0]                     nxt_valid_o,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     nxt_rd_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rf_wr_t [DEPTH-1:0] mem_q;
    logic   [DEPTH-1:0] valid_q, valid_d;
    logic   [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic   [CNT_W-1:0] count_q, count_d;

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Entry occupancy and destination as they will be after this edge.
    always_comb begin
        valid_d = valid_q;
        if (pop_i) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push_i) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            nxt_rd_o[i] = mem_q[i].rd;
            if (push_i && (wr_ptr_q == PTR_W'(i))) begin
                nxt_rd_o[i] = data_i.rd;
            end
        end
        nxt_valid_o = valid_d;
    end

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage and pointers; power-of-two depth makes the pointer wrap free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Write-side front end of the register file port (A3/WD3/WE3).
// The pipeline writeback stream has fixed priority; long-latency results are
// buffered and drained on cycles the pipeline leaves the port idle.
// Ports:
//   clk, rst                      clock, async active-low reset
//   wb_valid/wb_rd/wb_data        pipeline writeback (cannot be stalled)
//   mc_valid/mc_rd/mc_data        long-latency result, handshaked with mc_ready
//   rf_a3/rf_wd3/rf_we3           registered register file write port
//   pending_mask                  registers with a buffered write outstanding
//   stall_req                     buffered writes starved; ask for a wb bubble
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  mc_valid,
    input  logic [REG_ADDR_W-1:0] mc_rd,
    input  logic [XLEN-1:0]       mc_data,
    output logic                  mc_ready,
    output logic [REG_ADDR_W-1:0] rf_a3,
    output logic [XLEN-1:0]       rf_wd3,
    output logic                  rf_we3,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic                  stall_req
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    logic                              wb_win, push_en, pop_en;
    rf_wr_t                            push_data, head;
    logic [CNT_W-1:0]                  fifo_count, count_after;
    logic                              fifo_full, fifo_empty;
    logic [DEPTH-1:0]                  nxt_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]  nxt_rd;

    logic                  mc_ready_q, mc_ready_d;
    logic                  rf_we3_q, rf_we3_d;
    logic [REG_ADDR_W-1:0] rf_a3_q, rf_a3_d;
    logic [XLEN-1:0]       rf_wd3_q, rf_wd3_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [STV_W-1:0]      starve_q, starve_d;
    logic                  stall_q, stall_d;

    assign push_data.rd   = mc_rd;
    assign push_data.data = mc_data;

    rf_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_en),
        .data_i      (push_data),
        .pop_i       (pop_en),
        .head_o      (head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .nxt_valid_o (nxt_valid),
        .nxt_rd_o    (nxt_rd)
    );

    // Port selection, buffer control, starvation tracking and pending mask.
    always_comb begin
        wb_win      = wb_valid && (wb_rd != '0);
        // The pop decision uses the registered occupancy, so a result pushed
        // this cycle cannot bypass to the port in the same cycle.
        pop_en      = !wb_win && !fifo_empty;
        // Writes to x0 complete the handshake but are dropped.
        push_en     = mc_valid && mc_ready_q && (mc_rd != '0) && !fifo_full;

        rf_we3_d    = wb_win || pop_en;
        rf_a3_d     = rf_a3_q;
        rf_wd3_d    = rf_wd3_q;
        if (wb_win) begin
            rf_a3_d  = wb_rd;
            rf_wd3_d = wb_data;
        end else if (pop_en) begin
            rf_a3_d  = head.rd;
            rf_wd3_d = head.data;
        end

        count_after = fifo_count + CNT_W'(push_en) - CNT_W'(pop_en);
        mc_ready_d  = (count_after < CNT_W'(DEPTH));

        starve_d    = starve_q;
        if (fifo_empty || pop_en) begin
            starve_d = '0;
        end else if (wb_win && (starve_q != STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end
        stall_d     = (starve_d == STV_W'(STARVE_LIMIT));

        pending_d   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (nxt_valid[i]) begin
                pending_d = pending_d | rd_onehot(nxt_rd[i]);
            end
        end
    end

    // Output and control registers; reset drops the write enable immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc_ready_q <= 1'b0;
            rf_we3_q   <= 1'b0;
            rf_a3_q    <= '0;
            rf_wd3_q   <= '0;
            pending_q  <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
        end else begin
            mc_ready_q <= mc_ready_d;
            rf_we3_q   <= rf_we3_d;
            rf_a3_q    <= rf_a3_d;
            rf_wd3_q   <= rf_wd3_d;
            pending_q  <= pending_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
        end
    end

    assign mc_ready     = mc_ready_q;
    assign rf_we3       = rf_we3_q;
    assign rf_a3        = rf_a3_q;
    assign rf_wd3       = rf_wd3_q;
    assign pending_mask = pending_q;
    assign stall_req    = stall_q;

endmodule
